// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI-to-register-bus bridge.
package spi_reg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WDATA,
        S_WBUS,
        S_RBUS,
        S_RDATA
    } state_t;

    // Command flag positions counted down from the word MSB, so they follow K_DWIDTH.
    localparam int CMD_RNW_FROM_MSB = 0;
    localparam int CMD_INC_FROM_MSB = 1;

    // Word returned to the SPI master when a read times out; sliced to K_DWIDTH.
    localparam logic [63:0] TIMEOUT_FILL = '1;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Signal bundle between the SPI slave / register bus and spi_reg_ctrl.
interface spi_reg_ctrl_if #(
    parameter int K_DWIDTH = 16,
    parameter int K_AWIDTH = 8
);
    // i_rx_event and o_tx_valid are single-cycle strobes with no backpressure;
    // o_reg_we/o_reg_re stay high with address/data stable until i_reg_ack or timeout.
    logic                i_selected;
    logic [K_DWIDTH-1:0] i_rx_data;
    logic                i_rx_event;
    logic [K_DWIDTH-1:0] o_tx_data;
    logic                o_tx_valid;
    logic [K_AWIDTH-1:0] o_reg_addr;
    logic [K_DWIDTH-1:0] o_reg_wdata;
    logic                o_reg_we;
    logic                o_reg_re;
    logic [K_DWIDTH-1:0] i_reg_rdata;
    logic                i_reg_ack;
    logic                o_busy;
    logic                o_err;

    modport master (
        input  i_selected, i_rx_data, i_rx_event, i_reg_rdata, i_reg_ack,
        output o_tx_data, o_tx_valid, o_reg_addr, o_reg_wdata,
               o_reg_we, o_reg_re, o_busy, o_err
    );

    modport slave (
        output i_selected, i_rx_data, i_rx_event, i_reg_rdata, i_reg_ack,
        input  o_tx_data, o_tx_valid, o_reg_addr, o_reg_wdata,
               o_reg_we, o_reg_re, o_busy, o_err
    );

endinterface

// File: rtl/spi_reg_ctrl.sv
// Translates SPI command/data words into register-bus reads and writes
// with optional address auto-increment, bus timeout and overrun detection.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int K_DWIDTH  = 16,
    parameter int K_AWIDTH  = 8,
    parameter int K_TIMEOUT = 15
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    spi_reg_ctrl_if.master bus,
    output state_t         o_dbg_state
);

    localparam int              K_CW        = $clog2(K_TIMEOUT + 1);
    localparam int              K_RNW_POS   = K_DWIDTH - 1 - CMD_RNW_FROM_MSB;
    localparam int              K_INC_POS   = K_DWIDTH - 1 - CMD_INC_FROM_MSB;
    localparam logic [K_CW-1:0] K_WAIT_LAST = K_CW'(K_TIMEOUT - 1);

    state_t              state_q, state_d;
    logic                sel_prev_q;
    logic [K_AWIDTH-1:0] addr_q, addr_d;
    logic                rnw_q, rnw_d;
    logic                inc_q, inc_d;
    logic [K_DWIDTH-1:0] wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                re_q, re_d;
    logic [K_DWIDTH-1:0] tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                err_q, err_d;
    logic [K_CW-1:0]     wait_q, wait_d;
    logic [K_AWIDTH-1:0] addr_next;

    assign addr_next = addr_q + K_AWIDTH'(inc_q);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            // Treat select as already high so a transaction in flight at
            // reset release is ignored until a fresh rising edge.
            sel_prev_q <= 1'b1;
            addr_q     <= '0;
            rnw_q      <= 1'b0;
            inc_q      <= 1'b0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            sel_prev_q <= bus.i_selected;
            addr_q     <= addr_d;
            rnw_q      <= rnw_d;
            inc_q      <= inc_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            re_q       <= re_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
            wait_q     <= wait_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rnw_d      = rnw_q;
        inc_d      = inc_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        re_d       = re_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        err_d      = 1'b0;
        wait_d     = wait_q;

        if (state_q != S_IDLE && !bus.i_selected) begin
            state_d = S_IDLE;
            we_d    = 1'b0;
            re_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.i_selected && !sel_prev_q) state_d = S_CMD;
                end
                S_CMD: begin
                    if (bus.i_rx_event) begin
                        addr_d = bus.i_rx_data[K_AWIDTH-1:0];
                        rnw_d  = bus.i_rx_data[K_RNW_POS];
                        inc_d  = bus.i_rx_data[K_INC_POS];
                        wait_d = '0;
                        if (bus.i_rx_data[K_RNW_POS]) begin
                            re_d    = 1'b1;
                            state_d = S_RBUS;
                        end else begin
                            state_d = S_WDATA;
                        end
                    end
                end
                S_WDATA: begin
                    if (bus.i_rx_event) begin
                        wdata_d = bus.i_rx_data;
                        we_d    = 1'b1;
                        wait_d  = '0;
                        state_d = S_WBUS;
                    end
                end
                S_WBUS: begin
                    if (bus.i_rx_event) err_d = 1'b1;
                    if (bus.i_reg_ack || wait_q == K_WAIT_LAST) begin
                        if (!bus.i_reg_ack) err_d = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = addr_next;
                        state_d = S_WDATA;
                    end else begin
                        wait_d = wait_q + K_CW'(1);
                    end
                end
                S_RBUS: begin
                    if (bus.i_rx_event) err_d = 1'b1;
                    if (bus.i_reg_ack || wait_q == K_WAIT_LAST) begin
                        if (bus.i_reg_ack) begin
                            tx_data_d = bus.i_reg_rdata;
                        end else begin
                            tx_data_d = TIMEOUT_FILL[K_DWIDTH-1:0];
                            err_d     = 1'b1;
                        end
                        tx_valid_d = 1'b1;
                        re_d       = 1'b0;
                        state_d    = S_RDATA;
                    end else begin
                        wait_d = wait_q + K_CW'(1);
                    end
                end
                S_RDATA: begin
                    // The dummy word that shifted the read data out triggers the next read.
                    if (bus.i_rx_event) begin
                        addr_d  = addr_next;
                        re_d    = 1'b1;
                        wait_d  = '0;
                        state_d = S_RBUS;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    we_d    = 1'b0;
                    re_d    = 1'b0;
                end
            endcase
        end
    end

    assign bus.o_tx_data   = tx_data_q;
    assign bus.o_tx_valid  = tx_valid_q;
    assign bus.o_reg_addr  = addr_q;
    assign bus.o_reg_wdata = wdata_q;
    assign bus.o_reg_we    = we_q;
    assign bus.o_reg_re    = re_q;
    assign bus.o_busy      = (state_q != S_IDLE);
    assign bus.o_err       = err_q;
    assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: transaction-level model predicts register accesses,
// SPI tx loads and error pulses; a negedge monitor scores the DUT against it.
module tb_spi_reg_ctrl;
  import spi_reg_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int TO    = 15;
  localparam int ACC_W = 1 + 8 + AW + DW;  // {is_write, expected strobe length (0 = any), addr, data}

  logic   clk;
  logic   rst_n;
  state_t dbg_state;

  spi_reg_ctrl_if #(.K_DWIDTH(DW), .K_AWIDTH(AW)) bus ();

  spi_reg_ctrl #(.K_DWIDTH(DW), .K_AWIDTH(AW), .K_TIMEOUT(TO)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t exceeded limit 500000", $time);
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [ACC_W-1:0] exp_acc_q[$];
  logic [DW-1:0]    exp_tx_q[$];
  logic [DW-1:0]    mem[256];
  logic [DW-1:0]    ref_mem[256];
  logic [DW-1:0]    wbuf[8];
  int               n_chk = 0;
  int               n_pass = 0;
  int               exp_err = 0;
  int               err_seen = 0;
  int               ack_lat = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  // driver tasks (all inputs change #1 after a rising edge)
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int gap();
    return 20 + $urandom_range(0, 3);
  endfunction

  task automatic send_word(input logic [DW-1:0] w);
    bus.i_rx_data  = w;
    bus.i_rx_event = 1'b1;
    tick(1);
    bus.i_rx_event = 1'b0;
    bus.i_rx_data  = DW'($urandom);
  endtask

  task automatic end_checks();
    chk("err_count", 32'(err_seen), 32'(exp_err));
    chk("acc_left", 32'(exp_acc_q.size()), 32'd0);
    chk("tx_left", 32'(exp_tx_q.size()), 32'd0);
  endtask

  // lat = 0 means the register bus never acknowledges
  task automatic run_txn(input bit rnw, input bit inc, input logic [AW-1:0] addr,
                         input int n, input int lat, input logic [5:0] pad);
    logic [AW-1:0] a;
    logic [7:0]    len;
    a   = addr;
    len = (lat == 0) ? 8'(TO) : 8'd0;
    if (!rnw) begin
      for (int i = 0; i < n; i++) begin
        exp_acc_q.push_back({1'b1, len, a, wbuf[i]});
        if (lat != 0) ref_mem[a] = wbuf[i];
        else exp_err++;
        a = a + AW'(inc);
      end
    end else begin
      for (int i = 0; i <= n; i++) begin
        exp_acc_q.push_back({1'b0, len, a, {DW{1'b0}}});
        exp_tx_q.push_back((lat != 0) ? ref_mem[a] : {DW{1'b1}});
        if (lat == 0) exp_err++;
        a = a + AW'(inc);
      end
    end
    ack_lat = lat;
    bus.i_selected = 1'b1;
    tick(1);
    chk("sel_to_cmd", 32'(dbg_state), 32'(S_CMD));
    tick(1);
    send_word({rnw, inc, pad, addr});
    tick(gap());
    for (int i = 0; i < n; i++) begin
      send_word(rnw ? DW'($urandom) : wbuf[i]);
      tick(gap());
    end
    bus.i_selected = 1'b0;
    tick(3);
    end_checks();
  endtask

  task automatic run_overrun(input logic [AW-1:0] addr, input logic [DW-1:0] w);
    exp_acc_q.push_back({1'b1, 8'd0, addr, w});
    ref_mem[addr] = w;
    exp_err++;
    ack_lat = 6;
    bus.i_selected = 1'b1;
    tick(2);
    send_word({1'b0, 1'b1, 6'd0, addr});
    tick(gap());
    send_word(w);
    send_word(~w);
    tick(gap());
    bus.i_selected = 1'b0;
    tick(3);
    end_checks();
  endtask

  task automatic run_desel_rbus(input logic [AW-1:0] addr);
    exp_acc_q.push_back({1'b0, 8'd0, addr, {DW{1'b0}}});
    ack_lat = 0;
    bus.i_selected = 1'b1;
    tick(2);
    send_word({1'b1, 1'b0, 6'd0, addr});
    tick(5);
    chk("re_before_desel", 32'(bus.o_reg_re), 32'd1);
    bus.i_selected = 1'b0;
    tick(1);
    chk("desel_re_drop", 32'(bus.o_reg_re), 32'd0);
    chk("desel_state", 32'(dbg_state), 32'(S_IDLE));
    chk("desel_busy", 32'(bus.o_busy), 32'd0);
    tick(3);
    end_checks();
  endtask

  task automatic run_reset_wbus(input logic [AW-1:0] addr, input logic [DW-1:0] w);
    exp_acc_q.push_back({1'b1, 8'd0, addr, w});
    ack_lat = 0;
    bus.i_selected = 1'b1;
    tick(2);
    send_word({1'b0, 1'b0, 6'd0, addr});
    tick(3);
    send_word(w);
    tick(2);
    chk("we_before_rst", 32'(bus.o_reg_we), 32'd1);
    chk("busy_before_rst", 32'(bus.o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_we_async", 32'(bus.o_reg_we), 32'd0);
    chk("rst_busy_async", 32'(bus.o_busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("rst_addr", 32'(bus.o_reg_addr), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("rst_release_idle", 32'(dbg_state), 32'(S_IDLE));
    bus.i_selected = 1'b0;
    tick(2);
    end_checks();
  endtask

  // register-bus responder: acks after ack_lat visible strobe cycles
  int rsp_cnt  = 0;
  bit rsp_done = 1'b0;
  initial begin
    bus.i_reg_ack   = 1'b0;
    bus.i_reg_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.i_reg_ack   = 1'b0;
      bus.i_reg_rdata = DW'($urandom);
      if (!rst_n || !(bus.o_reg_we || bus.o_reg_re)) begin
        rsp_cnt  = 0;
        rsp_done = 1'b0;
      end else if (!rsp_done) begin
        rsp_cnt++;
        if (ack_lat != 0 && rsp_cnt >= ack_lat) begin
          bus.i_reg_ack = 1'b1;
          if (bus.o_reg_re) bus.i_reg_rdata = mem[bus.o_reg_addr];
          if (bus.o_reg_we) mem[bus.o_reg_addr] = bus.o_reg_wdata;
          rsp_done = 1'b1;
        end
      end
    end
  end

  // monitor / scoreboard
  logic             prev_strobe = 1'b0;
  logic             prev_txv = 1'b0;
  logic             prev_err = 1'b0;
  int               run_len = 0;
  logic [7:0]       cur_len_exp = 8'd0;
  logic [AW-1:0]    held_addr = '0;
  logic [DW-1:0]    held_data = '0;
  logic [ACC_W-1:0] e_acc;
  logic             strobe;

  always @(negedge clk) begin
    strobe = bus.o_reg_we | bus.o_reg_re;
    if (strobe && !prev_strobe) begin
      chk("acc_expected", 32'(exp_acc_q.size() != 0), 32'd1);
      cur_len_exp = 8'd0;
      if (exp_acc_q.size() != 0) begin
        e_acc = exp_acc_q.pop_front();
        chk("acc_kind", 32'({bus.o_reg_we, bus.o_reg_re}), 32'({e_acc[ACC_W-1], ~e_acc[ACC_W-1]}));
        chk("acc_addr", 32'(bus.o_reg_addr), 32'(e_acc[DW +: AW]));
        if (e_acc[ACC_W-1]) chk("acc_wdata", 32'(bus.o_reg_wdata), 32'(e_acc[DW-1:0]));
        cur_len_exp = e_acc[DW+AW +: 8];
      end
      run_len   = 0;
      held_addr = bus.o_reg_addr;
      held_data = bus.o_reg_wdata;
    end
    if (strobe) begin
      if (prev_strobe) chk("acc_hold", 32'({bus.o_reg_addr, bus.o_reg_wdata}), 32'({held_addr, held_data}));
      run_len++;
    end
    if (!strobe && prev_strobe && cur_len_exp != 0) chk("acc_len", 32'(run_len), 32'(cur_len_exp));
    if (bus.o_tx_valid) begin
      chk("txv_width", 32'(prev_txv), 32'd0);
      chk("tx_expected", 32'(exp_tx_q.size() != 0), 32'd1);
      if (exp_tx_q.size() != 0) chk("tx_data", 32'(bus.o_tx_data), 32'(exp_tx_q.pop_front()));
    end
    if (bus.o_err) begin
      err_seen++;
      chk("err_width", 32'(prev_err), 32'd0);
    end
    prev_strobe = strobe;
    prev_txv    = bus.o_tx_valid;
    prev_err    = bus.o_err;
  end

  // main sequence
  initial begin
    bit            r_rnw;
    bit            r_inc;
    int            r_n;
    int            r_lat;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] v;

    for (int i = 0; i < 256; i++) begin
      v          = DW'($urandom);
      mem[i]     = v;
      ref_mem[i] = v;
    end
    rst_n          = 1'b0;
    bus.i_selected = 1'b1;
    bus.i_rx_data  = '0;
    bus.i_rx_event = 1'b0;
    tick(2);
    chk("rst_tx_data", 32'(bus.o_tx_data), 32'd0);
    chk("rst_tx_valid", 32'(bus.o_tx_valid), 32'd0);
    chk("rst_reg_addr", 32'(bus.o_reg_addr), 32'd0);
    chk("rst_reg_wdata", 32'(bus.o_reg_wdata), 32'd0);
    chk("rst_we_re", 32'({bus.o_reg_we, bus.o_reg_re}), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_err", 32'(bus.o_err), 32'd0);
    chk("rst_state_idle", 32'(dbg_state), 32'(S_IDLE));
    rst_n = 1'b1;
    tick(4);
    chk("no_start_while_held", 32'(dbg_state), 32'(S_IDLE));
    chk("no_busy_while_held", 32'(bus.o_busy), 32'd0);
    bus.i_selected = 1'b0;
    tick(2);

    // cmd 0x4010, data 0x1234, ack after 2
    wbuf[0] = 16'h1234;
    run_txn(1'b0, 1'b1, 8'h10, 1, 2, 6'd0);
    chk("mem_0x10", 32'(mem[8'h10]), 32'h1234);

    // cmd 0xC0FF, three dummies, address wraps through 0x00
    run_txn(1'b1, 1'b1, 8'hFF, 3, 1, 6'd0);

    // cmd 0x8005 with no ack: timeout fill
    run_txn(1'b1, 1'b0, 8'h05, 0, 0, 6'd0);

    run_overrun(8'h33, 16'hA5C3);
    run_desel_rbus(8'h44);
    run_txn(1'b1, 1'b0, 8'h44, 1, 3, 6'd0);
    run_reset_wbus(8'h55, 16'h0F0F);
    chk("mem_0x55_untouched", 32'(mem[8'h55]), 32'(ref_mem[8'h55]));

    for (int t = 0; t < 40; t++) begin
      r_rnw  = 1'($urandom_range(0, 1));
      r_inc  = 1'($urandom_range(0, 1));
      r_n    = $urandom_range(1, 4);
      r_lat  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      r_addr = ($urandom_range(0, 3) == 0) ? 8'hFE : AW'($urandom);
      for (int i = 0; i < r_n; i++) wbuf[i] = DW'($urandom);
      run_txn(r_rnw, r_inc, r_addr, r_n, r_lat, 6'($urandom));
    end

    end_checks();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
